nor_bank_clk: RTL and testbench

NOR_BANK_CLK -- requirements
Module: nor_bank_clk

---
 rtl/agc_gate_pkg.sv | 18 +
 rtl/nor_bank_clk_nor_cell.sv | 89 ++++++++
 rtl/nor_bank_clk.sv | 76 +++++++
 tb/tb_nor_bank_clk.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/agc_gate_pkg.sv
// Shared encodings and limits for the clocked NOR gate bank.
package agc_gate_pkg;

   localparam int unsigned MODE_TRANSPORT = 0;
   localparam int unsigned MODE_INERTIAL  = 1;

   localparam int unsigned MAX_GATES  = 16;
   localparam int unsigned MAX_INPUTS = 4;
   localparam int unsigned MAX_DELAY  = 15;

   // Adds up to 16 simultaneous swallow events, clamping at 255.
   function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [4:0] inc);
      logic [8:0] sum;
      sum = {1'b0, acc} + {4'b0000, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/nor_bank_clk_nor_cell.sv
// One NOR gate with a clocked transport or inertial delay path.
module nor_cell
   import agc_gate_pkg::*;
#(
   parameter int unsigned INPUTS = 2,
   parameter int unsigned DELAY  = 9,
   parameter int unsigned MODE   = MODE_TRANSPORT,
   parameter logic        IC_BIT = 1'b0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              force_i,
   input  logic [INPUTS-1:0] a,
   output logic              y,
   output logic              pending,
   output logic              swallow
);

   logic n;
   assign n = ~((|a) | force_i);

   generate
      if (MODE == MODE_TRANSPORT) begin : g_transport
         logic [DELAY-1:0] sr_q, sr_d;

         always_comb begin
            sr_d = sr_q;
            if (en) begin
               sr_d[0] = n;
               for (int unsigned s = 1; s < DELAY; s++) begin
                  sr_d[s] = sr_q[s-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr_q <= {DELAY{IC_BIT}};
            end else begin
               sr_q <= sr_d;
            end
         end

         // The oldest stage is the output, so it never counts as in flight.
         assign y       = sr_q[DELAY-1];
         assign pending = (sr_q != {DELAY{y}});
         assign swallow = 1'b0;
      end else begin : g_inertial
         logic [3:0] cnt_q, cnt_d;
         logic       y_q, y_d;
         logic       swallow_d;

         always_comb begin
            cnt_d     = cnt_q;
            y_d       = y_q;
            swallow_d = 1'b0;
            if (en) begin
               if (n != y_q) begin
                  if (cnt_q + 4'd1 == 4'(DELAY)) begin
                     y_d   = ~y_q;
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else if (cnt_q != '0) begin
                  cnt_d     = '0;
                  swallow_d = 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
               y_q   <= IC_BIT;
            end else begin
               cnt_q <= cnt_d;
               y_q   <= y_d;
            end
         end

         assign y       = y_q;
         assign pending = (cnt_q != '0);
         assign swallow = swallow_d;
      end
   endgenerate

endmodule

// File: rtl/nor_bank_clk.sv
// Bank of independent clocked NOR gates with a shared swallowed-pulse counter.
module nor_bank_clk
   import agc_gate_pkg::*;
#(
   parameter int unsigned      GATES  = 4,
   parameter int unsigned      INPUTS = 2,
   parameter int unsigned      DELAY  = 9,
   parameter logic [GATES-1:0] IC     = '0,
   parameter int unsigned      MODE   = MODE_TRANSPORT
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   // force is a reserved word, so the forcing term is carried on force_i.
   input  logic                    force_i,
   input  logic [GATES*INPUTS-1:0] a,
   output logic [GATES-1:0]        y,
   output logic [GATES-1:0]        pending,
   output logic [7:0]              swallowed
);

   generate
      if (GATES < 1 || GATES > MAX_GATES || INPUTS < 1 || INPUTS > MAX_INPUTS ||
          DELAY < 1 || DELAY > MAX_DELAY ||
          (MODE != MODE_TRANSPORT && MODE != MODE_INERTIAL)) begin : g_bad_param
         $error("nor_bank_clk: illegal parameter value");
      end
   endgenerate

   logic [GATES-1:0] swallow;

   generate
      for (genvar g = 0; g < GATES; g++) begin : g_gate
         nor_cell #(
            .INPUTS (INPUTS),
            .DELAY  (DELAY),
            .MODE   (MODE),
            .IC_BIT (IC[g])
         ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .force_i (force_i),
            .a       (a[g*INPUTS +: INPUTS]),
            .y       (y[g]),
            .pending (pending[g]),
            .swallow (swallow[g])
         );
      end
   endgenerate

   logic [4:0] swallow_cnt;
   logic [7:0] swallowed_q, swallowed_d;

   always_comb begin
      swallow_cnt = '0;
      for (int unsigned g = 0; g < GATES; g++) begin
         swallow_cnt = swallow_cnt + 5'(swallow[g]);
      end
      swallowed_d = swallowed_q;
      if (en) begin
         swallowed_d = sat_add8(swallowed_q, swallow_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swallowed_q <= '0;
      end else begin
         swallowed_q <= swallowed_d;
      end
   end

   assign swallowed = swallowed_q;

endmodule

// File: tb/tb_nor_bank_clk.sv
// Directed checks of the NOR bank in transport and inertial modes.
module tb_nor_bank_clk;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // T: transport, DELAY 9, IC 0101
   logic       t_en, t_frc;
   logic [7:0] t_a;
   logic [3:0] t_y, t_pend;
   logic [7:0] t_sw;
   // P: transport, DELAY 3
   logic       p_en, p_frc;
   logic [7:0] p_a;
   logic [3:0] p_y, p_pend;
   logic [7:0] p_sw;
   // I: inertial, DELAY 4
   logic       i_en, i_frc;
   logic [7:0] i_a;
   logic [3:0] i_y, i_pend;
   logic [7:0] i_sw;
   // S: inertial, DELAY 2
   logic       s_en, s_frc;
   logic [7:0] s_a;
   logic [3:0] s_y, s_pend;
   logic [7:0] s_sw;
   // D0/D1: DELAY 1, 3-input gates, transport and inertial on shared inputs
   logic       d_en, d_frc;
   logic [5:0] d_a;
   logic [1:0] d0_y, d0_pend, d1_y, d1_pend;
   logic [7:0] d0_sw, d1_sw;

   nor_bank_clk #(.GATES(4), .INPUTS(2), .DELAY(9), .IC(4'b0101), .MODE(0)) u_t (
      .clk(clk), .rst_n(rst_n), .en(t_en), .force_i(t_frc), .a(t_a),
      .y(t_y), .pending(t_pend), .swallowed(t_sw));
   nor_bank_clk #(.GATES(4), .INPUTS(2), .DELAY(3), .IC(4'b0000), .MODE(0)) u_p (
      .clk(clk), .rst_n(rst_n), .en(p_en), .force_i(p_frc), .a(p_a),
      .y(p_y), .pending(p_pend), .swallowed(p_sw));
   nor_bank_clk #(.GATES(4), .INPUTS(2), .DELAY(4), .IC(4'b0000), .MODE(1)) u_i (
      .clk(clk), .rst_n(rst_n), .en(i_en), .force_i(i_frc), .a(i_a),
      .y(i_y), .pending(i_pend), .swallowed(i_sw));
   nor_bank_clk #(.GATES(4), .INPUTS(2), .DELAY(2), .IC(4'b0000), .MODE(1)) u_s (
      .clk(clk), .rst_n(rst_n), .en(s_en), .force_i(s_frc), .a(s_a),
      .y(s_y), .pending(s_pend), .swallowed(s_sw));
   nor_bank_clk #(.GATES(2), .INPUTS(3), .DELAY(1), .IC(2'b00), .MODE(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .en(d_en), .force_i(d_frc), .a(d_a),
      .y(d0_y), .pending(d0_pend), .swallowed(d0_sw));
   nor_bank_clk #(.GATES(2), .INPUTS(3), .DELAY(1), .IC(2'b00), .MODE(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .en(d_en), .force_i(d_frc), .a(d_a),
      .y(d1_y), .pending(d1_pend), .swallowed(d1_sw));

   typedef struct {
      logic [5:0] a;
      logic       f;
      logic [1:0] y;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{a: 6'b000000, f: 1'b0, y: 2'b11};
      vecs[1] = '{a: 6'b000001, f: 1'b0, y: 2'b10};
      vecs[2] = '{a: 6'b001000, f: 1'b0, y: 2'b01};
      vecs[3] = '{a: 6'b100100, f: 1'b0, y: 2'b00};
      vecs[4] = '{a: 6'b000000, f: 1'b1, y: 2'b00};
      vecs[5] = '{a: 6'b000000, f: 1'b0, y: 2'b11};
      vecs[6] = '{a: 6'b010000, f: 1'b0, y: 2'b01};
      vecs[7] = '{a: 6'b000010, f: 1'b0, y: 2'b10};

      {t_en, p_en, i_en, s_en, d_en}      = '1;
      {t_frc, p_frc, i_frc, s_frc, d_frc} = '0;
      t_a = '0; p_a = '0; i_a = '0; s_a = '0; d_a = '0;

      // Reset state
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_y", 32'(t_y), 32'h5);
      chk("rst_pend", 32'(t_pend), 32'h0);
      chk("rst_sw", 32'(t_sw), 32'h0);
      tick();
      chk("rst_hold_y", 32'(t_y), 32'h5);
      #2 rst_n = 1'b1;

      // Transport, DELAY 9, a=0
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("tr_y_e%0d", k), 32'(t_y), (k >= 9) ? 32'hF : 32'h5);
         chk($sformatf("tr_pend_e%0d", k), 32'(t_pend), (k >= 9) ? 32'h0 : 32'hA);
      end
      chk("settle_p_y", 32'(p_y), 32'hF);
      chk("settle_i_y", 32'(i_y), 32'hF);
      chk("settle_s_y", 32'(s_y), 32'hF);

      // DELAY 1 table, both modes
      for (int v = 0; v < 8; v++) begin
         d_a   = vecs[v].a;
         d_frc = vecs[v].f;
         tick();
         chk($sformatf("d1tr_y_v%0d", v), 32'(d0_y), 32'(vecs[v].y));
         chk($sformatf("d1in_y_v%0d", v), 32'(d1_y), 32'(vecs[v].y));
      end
      chk("d1in_sw", 32'(d1_sw), 32'h0);
      chk("d1in_pend", 32'(d1_pend), 32'h0);

      // Transport pulse passes, DELAY 3
      p_a = 8'h01;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 2) p_a = '0;
         chk($sformatf("tp_y_e%0d", k), 32'(p_y), (k == 3 || k == 4) ? 32'hE : 32'hF);
         if (k == 1) chk("tp_pend_e1", 32'(p_pend), 32'h1);
      end
      chk("tp_pend_end", 32'(p_pend), 32'h0);
      chk("tp_sw", 32'(p_sw), 32'h0);

      // Inertial, DELAY 4: 3-cycle pulse swallowed
      chk("in_sw0", 32'(i_sw), 32'h0);
      i_a = 8'h01;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("in3_y_e%0d", k), 32'(i_y), 32'hF);
         chk($sformatf("in3_pend_e%0d", k), 32'(i_pend), 32'h1);
      end
      i_a = '0;
      tick();
      chk("in3_y_end", 32'(i_y), 32'hF);
      chk("in3_pend_end", 32'(i_pend), 32'h0);
      chk("in3_sw", 32'(i_sw), 32'h1);
      // 4-cycle pulse propagates
      i_a = 8'h01;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("in4_y_e%0d", k), 32'(i_y), (k == 4) ? 32'hE : 32'hF);
      end
      i_a = '0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 3) chk("in4_back_pend", 32'(i_pend), 32'h1);
      end
      chk("in4_back_y", 32'(i_y), 32'hF);
      chk("in4_sw", 32'(i_sw), 32'h1);

      // Saturation, DELAY 2, 4 gates swallowing per round
      for (int r = 1; r <= 70; r++) begin
         s_a = 8'hFF;
         tick();
         s_a = '0;
         tick();
         chk($sformatf("sat_r%0d", r), 32'(s_sw), (4 * r > 255) ? 32'd255 : 32'(4 * r));
      end
      chk("sat_y", 32'(s_y), 32'hF);

      // Freeze mid-delay
      t_a = 8'h55;
      for (int k = 1; k <= 4; k++) tick();
      chk("frz_pre_y", 32'(t_y), 32'hF);
      chk("frz_pre_pend", 32'(t_pend), 32'hF);
      t_en  = 1'b0;
      t_a   = 8'h00;
      t_frc = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("frz_y_c%0d", k), 32'(t_y), 32'hF);
         chk($sformatf("frz_pend_c%0d", k), 32'(t_pend), 32'hF);
      end
      t_en  = 1'b1;
      t_a   = 8'h55;
      t_frc = 1'b0;
      for (int k = 5; k <= 9; k++) begin
         tick();
         chk($sformatf("frz_resume_y_e%0d", k), 32'(t_y), (k == 9) ? 32'h0 : 32'hF);
      end
      t_a = '0;
      for (int k = 1; k <= 9; k++) tick();
      chk("frc_pre_y", 32'(t_y), 32'hF);
      chk("frc_pre_pend", 32'(t_pend), 32'h0);

      // Force goes through the delay path
      t_frc = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("frc_y_e%0d", k), 32'(t_y), (k == 9) ? 32'h0 : 32'hF);
      end
      chk("frc_sw", 32'(t_sw), 32'h0);

      // Reset mid-operation
      t_frc = 1'b0;
      for (int k = 1; k <= 3; k++) tick();
      chk("mid_pend_pre", 32'(t_pend), 32'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_y", 32'(t_y), 32'h5);
      chk("mid_rst_pend", 32'(t_pend), 32'h0);
      chk("mid_rst_s_sw", 32'(s_sw), 32'h0);
      chk("mid_rst_i_sw", 32'(i_sw), 32'h0);
      tick();
      chk("mid_rst_hold_y", 32'(t_y), 32'h5);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_y", 32'(t_y), 32'h5);
      chk("post_rst_pend", 32'(t_pend), 32'hA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
